// File: rtl/priority_grant_decoder_if.sv
// Encoder-to-decoder select/grant bundle for priority_grant_decoder.
// The grant_cnt signal and the CNT_W parameter exist only when DEC_STATS_EN is defined.
interface priority_grant_decoder_if
`ifdef DEC_STATS_EN
    #(parameter int CNT_W = 8)
`endif
    ;
    logic       s0;
    logic       s1;
    logic       valid;
    logic       ready;
    logic       done;
    logic       g0;
    logic       g1;
    logic       g2;
    logic       g3;
    logic [1:0] active_sel;
    logic       timeout;
`ifdef DEC_STATS_EN
    logic [CNT_W-1:0] grant_cnt;

    modport master (
        output s0, s1, valid, done,
        input  ready, g0, g1, g2, g3, active_sel, timeout, grant_cnt
    );

    modport slave (
        input  s0, s1, valid, done,
        output ready, g0, g1, g2, g3, active_sel, timeout, grant_cnt
    );
`else
    modport master (
        output s0, s1, valid, done,
        input  ready, g0, g1, g2, g3, active_sel, timeout
    );

    modport slave (
        input  s0, s1, valid, done,
        output ready, g0, g1, g2, g3, active_sel, timeout
    );
`endif
endinterface

// File: rtl/priority_grant_decoder.sv
// Decodes the 2-bit priority select into a registered one-hot grant with hold timeout
// and break-before-make gap. Optional grant statistics counter under DEC_STATS_EN.
//
// state | meaning
// IDLE  | ready=1, waiting for valid to latch a select
// GRANT | one grant high; ends on done or on hold timeout
// GAP   | all grants low for one cycle before returning to IDLE
module priority_grant_decoder #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    priority_grant_decoder_if.slave bus
);

    localparam int HOLD_W = $clog2(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_TC = HOLD_W'(MAX_HOLD - 1);

    if (MAX_HOLD < 2 || MAX_HOLD > 65535) begin : g_bad_max_hold
        $error("priority_grant_decoder: MAX_HOLD out of range 2..65535");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("priority_grant_decoder: CNT_W must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t            state;
    logic [3:0]        grant;
    logic [1:0]        sel_q;
    logic              timeout_q;
    logic [HOLD_W-1:0] hold_cnt;
    logic [1:0]        sel_in;
    logic              ready_c;
    logic              xfer;

    assign sel_in  = {bus.s1, bus.s0};
    assign ready_c = (state == IDLE);
    assign xfer    = bus.valid & ready_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= 4'b0000;
            sel_q     <= 2'b00;
            timeout_q <= 1'b0;
            hold_cnt  <= '0;
        end else begin
            timeout_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (xfer) begin
                        sel_q    <= sel_in;
                        grant    <= 4'b0001 << sel_in;
                        hold_cnt <= '0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    // done takes priority, so a coincident timeout is swallowed
                    if (bus.done) begin
                        grant <= 4'b0000;
                        state <= GAP;
                    end else if (hold_cnt == HOLD_TC) begin
                        grant     <= 4'b0000;
                        timeout_q <= 1'b1;
                        state     <= GAP;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    grant <= 4'b0000;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready      = ready_c;
    assign bus.g0         = grant[0];
    assign bus.g1         = grant[1];
    assign bus.g2         = grant[2];
    assign bus.g3         = grant[3];
    assign bus.active_sel = sel_q;
    assign bus.timeout    = timeout_q;

`ifdef DEC_STATS_EN
    logic [CNT_W-1:0] grant_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt_q <= '0;
        end else if (xfer) begin
            grant_cnt_q <= grant_cnt_q + 1'b1;
        end
    end

    assign bus.grant_cnt = grant_cnt_q;
`endif

endmodule
